// File: rtl/battleship_turn_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : battleship_turn_ctrl
// Brief    : N-player battleship turn sequencer (setup, round-robin attacks,
//            redo-on-invalid with retry limit, elimination skip, win detect).
//            Optional aim-phase timeout: define BS_TURN_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
module battleship_turn_ctrl #(
    parameter int NUM_PLAYERS    = 2,
    parameter int MAX_REDO       = 3,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int PW             = $clog2(NUM_PLAYERS)
) (
    input  logic                     clk,
    input  logic                     clr_n,
    input  logic                     btn_start,
    input  logic [NUM_PLAYERS-1:0]   btn_fire,
    input  logic [NUM_PLAYERS-1:0]   alive,
    input  logic                     ok,
    output logic [NUM_PLAYERS-1:0]   setup_ld,
    output logic [NUM_PLAYERS-1:0]   atk_ld,
    output logic [NUM_PLAYERS-1:0]   tgt_ld,
    output logic [3*NUM_PLAYERS-1:0] disp,
    output logic [PW-1:0]            attacker,
    output logic [PW-1:0]            target,
    output logic                     game_over,
    output logic [PW-1:0]            winner
);

    localparam int c_RW = (MAX_REDO == 0) ? 1 : $clog2(MAX_REDO + 1);

    typedef enum logic [2:0] {
        S_SETUP  = 3'd0,
        S_AIM    = 3'd1,
        S_ATTACK = 3'd2,
        S_REDO   = 3'd3,
        S_SETTLE = 3'd4,
        S_OVER   = 3'd5
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [PW-1:0]   r_attacker, w_attacker_nxt;
    logic [PW-1:0]   r_target, w_target_nxt;
    logic [PW-1:0]   r_winner, w_winner_nxt;
    logic            r_game_over, w_game_over_nxt;
    logic [c_RW-1:0] r_redo_cnt, w_redo_cnt_nxt;
    logic            w_tmo_exp;

    // First alive index strictly after 'from', wrapping; 'from' itself is checked last.
    function automatic logic [PW-1:0] f_next_alive(input logic [PW-1:0] from,
                                                   input logic [NUM_PLAYERS-1:0] mask);
        logic [PW-1:0] res;
        logic          found;
        int            idx;
        res   = from;
        found = 1'b0;
        for (int k = 1; k <= NUM_PLAYERS; k++) begin
            idx = (int'(from) + k) % NUM_PLAYERS;
            if (!found && mask[idx]) begin
                res   = PW'(idx);
                found = 1'b1;
            end
        end
        return res;
    endfunction

    function automatic int f_popcount(input logic [NUM_PLAYERS-1:0] mask);
        int n;
        n = 0;
        for (int k = 0; k < NUM_PLAYERS; k++) n += int'(mask[k]);
        return n;
    endfunction

`ifdef BS_TURN_TIMEOUT_EN
    localparam int c_TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [c_TW-1:0] r_tmo_cnt;

    // Held at zero outside AIM so every entry starts a fresh window.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n)
            r_tmo_cnt <= '0;
        else if (r_state != S_AIM)
            r_tmo_cnt <= '0;
        else
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end

    assign w_tmo_exp = (r_tmo_cnt == c_TW'(TIMEOUT_CYCLES - 1));
`else
    assign w_tmo_exp = 1'b0;
`endif

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state     <= S_SETUP;
            r_attacker  <= '0;
            r_target    <= PW'(1);
            r_winner    <= '0;
            r_game_over <= 1'b0;
            r_redo_cnt  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_attacker  <= w_attacker_nxt;
            r_target    <= w_target_nxt;
            r_winner    <= w_winner_nxt;
            r_game_over <= w_game_over_nxt;
            r_redo_cnt  <= w_redo_cnt_nxt;
        end
    end

    logic [PW-1:0] w_first_att, w_rr_att;
    assign w_first_att = f_next_alive(PW'(NUM_PLAYERS - 1), alive);
    assign w_rr_att    = f_next_alive(r_attacker, alive);

    always_comb begin
        w_state_nxt     = r_state;
        w_attacker_nxt  = r_attacker;
        w_target_nxt    = r_target;
        w_winner_nxt    = r_winner;
        w_game_over_nxt = r_game_over;
        w_redo_cnt_nxt  = r_redo_cnt;
        setup_ld        = '0;
        atk_ld          = '0;
        tgt_ld          = '0;
        case (r_state)
            S_SETUP: begin
                setup_ld = '1;
                if (btn_start && f_popcount(alive) >= 2) begin
                    w_state_nxt    = S_AIM;
                    w_attacker_nxt = w_first_att;
                    w_target_nxt   = f_next_alive(w_first_att, alive);
                end
            end
            S_AIM: begin
                if (btn_fire[r_attacker]) begin
                    w_state_nxt = S_ATTACK;
                end else if (w_tmo_exp) begin
                    w_state_nxt    = S_SETTLE;
                    w_redo_cnt_nxt = '0;
                end
            end
            S_ATTACK: begin
                atk_ld[r_attacker] = 1'b1;
                tgt_ld[r_target]   = 1'b1;
                if (ok) begin
                    w_redo_cnt_nxt = '0;
                    w_state_nxt    = S_SETTLE;
                end else if (MAX_REDO != 0 && int'(r_redo_cnt) + 1 == MAX_REDO) begin
                    w_redo_cnt_nxt = '0;
                    w_state_nxt    = S_SETTLE;
                end else begin
                    w_redo_cnt_nxt = (&r_redo_cnt) ? r_redo_cnt : r_redo_cnt + 1'b1;
                    w_state_nxt    = S_REDO;
                end
            end
            S_REDO: begin
                w_state_nxt = S_AIM;
            end
            S_SETTLE: begin
                if (f_popcount(alive) <= 1) begin
                    w_state_nxt     = S_OVER;
                    w_game_over_nxt = 1'b1;
                    w_winner_nxt    = (f_popcount(alive) == 1) ? w_rr_att : r_attacker;
                end else begin
                    w_state_nxt    = S_AIM;
                    w_attacker_nxt = w_rr_att;
                    w_target_nxt   = f_next_alive(w_rr_att, alive);
                end
            end
            S_OVER: begin
                w_state_nxt = S_OVER;
            end
            default: begin
                w_state_nxt = S_SETUP;
            end
        endcase
    end

    for (genvar gi = 0; gi < NUM_PLAYERS; gi++) begin : g_disp
        logic [2:0] w_code;
        always_comb begin
            w_code = 3'd0;
            case (r_state)
                S_SETUP:  w_code = 3'd0;
                S_REDO:   w_code = (r_attacker == PW'(gi)) ? 3'd5 : 3'd2;
                S_OVER:   w_code = (r_winner == PW'(gi)) ? 3'd6 : 3'd7;
                default:  w_code = (r_attacker == PW'(gi)) ? 3'd1 : 3'd2;
            endcase
            if (r_state != S_OVER && !alive[gi])
                w_code = 3'd3;
        end
        assign disp[3*gi +: 3] = w_code;
    end

    assign attacker  = r_attacker;
    assign target    = r_target;
    assign winner    = r_winner;
    assign game_over = r_game_over;

endmodule
`default_nettype wire

// File: tb/tb_battleship_turn_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_battleship_turn_ctrl
// Brief    : Directed bench for battleship_turn_ctrl (2- and 4-player builds).
// Revision : 1.0
// ============================================================================
module tb_battleship_turn_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // 2-player instance
    logic       clr2_n, start2, ok2;
    logic [1:0] fire2, alive2, setup_ld2, atk_ld2, tgt_ld2;
    logic [5:0] disp2;
    logic [0:0] att2, tgt2, win2;
    logic       go2;

    // 4-player instance
    logic        clr4_n, start4, ok4;
    logic [3:0]  fire4, alive4, setup_ld4, atk_ld4, tgt_ld4;
    logic [11:0] disp4;
    logic [1:0]  att4, tgt4, win4;
    logic        go4;

    battleship_turn_ctrl #(.NUM_PLAYERS(2), .MAX_REDO(3), .TIMEOUT_CYCLES(8)) u_dut2 (
        .clk(clk), .clr_n(clr2_n), .btn_start(start2), .btn_fire(fire2),
        .alive(alive2), .ok(ok2), .setup_ld(setup_ld2), .atk_ld(atk_ld2),
        .tgt_ld(tgt_ld2), .disp(disp2), .attacker(att2), .target(tgt2),
        .game_over(go2), .winner(win2)
    );

    battleship_turn_ctrl #(.NUM_PLAYERS(4), .MAX_REDO(3), .TIMEOUT_CYCLES(8)) u_dut4 (
        .clk(clk), .clr_n(clr4_n), .btn_start(start4), .btn_fire(fire4),
        .alive(alive4), .ok(ok4), .setup_ld(setup_ld4), .atk_ld(atk_ld4),
        .tgt_ld(tgt_ld4), .disp(disp4), .attacker(att4), .target(tgt4),
        .game_over(go4), .winner(win4)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] atk_seen;

    initial begin
        clr2_n = 1'b0; start2 = 1'b0; ok2 = 1'b0; fire2 = 2'b00; alive2 = 2'b11;
        clr4_n = 1'b0; start4 = 1'b0; ok4 = 1'b0; fire4 = 4'b0000; alive4 = 4'b1111;
        #12;

        // ---------------- reset state ----------------
        chk("rst_setup_ld", 32'(setup_ld2), 32'h3);
        chk("rst_disp",     32'(disp2),     32'h0);
        chk("rst_att",      32'(att2),      32'h0);
        chk("rst_tgt",      32'(tgt2),      32'h1);
        chk("rst_go",       32'(go2),       32'h0);
        chk("rst_win",      32'(win2),      32'h0);
        chk("rst_atk_ld",   32'(atk_ld2),   32'h0);

        @(negedge clk);
        clr2_n = 1'b1; clr4_n = 1'b1; start2 = 1'b1;
        tick();
        start2 = 1'b0;
        chk("start_att",   32'(att2),      32'h0);
        chk("start_tgt",   32'(tgt2),      32'h1);
        chk("start_disp",  32'(disp2),     32'h11);
        chk("start_setup", 32'(setup_ld2), 32'h0);

        // ---------------- valid shot ----------------
        fire2 = 2'b01; ok2 = 1'b1;
        tick();
        chk("shot_atk_ld", 32'(atk_ld2), 32'h1);
        chk("shot_tgt_ld", 32'(tgt_ld2), 32'h2);
        fire2 = 2'b00;
        tick();
        chk("settle_atk_ld", 32'(atk_ld2), 32'h0);
        tick();
        chk("shot_att",  32'(att2),  32'h1);
        chk("shot_tgt",  32'(tgt2),  32'h0);
        chk("shot_disp", 32'(disp2), 32'h0A);

        // ---------------- redo limit ----------------
        ok2 = 1'b0;
        for (int r = 0; r < 2; r++) begin
            fire2 = 2'b10;
            tick();
            chk("redo_atk_ld", 32'(atk_ld2), 32'h2);
            fire2 = 2'b00;
            tick();
            chk("redo_disp", 32'(disp2), 32'h2A);
            tick();
            chk("redo_back_aim", 32'(disp2), 32'h0A);
        end
        fire2 = 2'b10;
        tick();
        fire2 = 2'b00;
        tick();
        chk("forfeit_settle_disp", 32'(disp2), 32'h0A);
        tick();
        chk("forfeit_att", 32'(att2), 32'h0);
        chk("forfeit_tgt", 32'(tgt2), 32'h1);
        fire2 = 2'b01;
        tick();
        fire2 = 2'b00;
        tick();
        chk("redo_cleared_disp", 32'(disp2), 32'h15);
        tick();

        // ---------------- win and async reset ----------------
        fire2 = 2'b01; ok2 = 1'b1;
        tick();
        alive2 = 2'b01; fire2 = 2'b00;
        tick();
        tick();
        chk("over_go",   32'(go2),   32'h1);
        chk("over_win",  32'(win2),  32'h0);
        chk("over_disp", 32'(disp2), 32'h3E);
        fire2 = 2'b11;
        tick();
        chk("over_hold_go",  32'(go2),     32'h1);
        chk("over_no_ld",    32'(atk_ld2), 32'h0);
        fire2 = 2'b00;
        clr2_n = 1'b0;
        #1;
        chk("arst_go",    32'(go2),       32'h0);
        chk("arst_setup", 32'(setup_ld2), 32'h3);
        chk("arst_disp",  32'(disp2),     32'h18);
        clr2_n = 1'b1; start2 = 1'b1;
        tick();
        chk("one_alive_stays_setup", 32'(setup_ld2), 32'h3);
        start2 = 1'b0;

        // ---------------- 4 players: ignored fire, elimination skip ----------------
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        chk("p4_att", 32'(att4), 32'h0);
        chk("p4_tgt", 32'(tgt4), 32'h1);
        fire4 = 4'b0100; ok4 = 1'b1;
        tick();
        chk("p4_foreign_fire_ld",   32'(atk_ld4), 32'h0);
        chk("p4_foreign_fire_disp", 32'(disp4),   32'h491);
        fire4 = 4'b0001;
        tick();
        chk("p4_atk_ld", 32'(atk_ld4), 32'h1);
        chk("p4_tgt_ld", 32'(tgt_ld4), 32'h2);
        alive4 = 4'b1101; fire4 = 4'b0000;
        tick();
        tick();
        chk("elim_att",  32'(att4),  32'h2);
        chk("elim_tgt",  32'(tgt4),  32'h3);
        chk("elim_disp", 32'(disp4), 32'h45A);
        fire4 = 4'b0100;
        tick();
        chk("elim_tgt_ld", 32'(tgt_ld4), 32'h8);
        fire4 = 4'b0000;
        tick();
        tick();
        chk("wrap_att", 32'(att4), 32'h3);
        chk("wrap_tgt", 32'(tgt4), 32'h0);
        fire4 = 4'b1000;
        tick();
        fire4 = 4'b0000;
        tick();
        tick();
        chk("skip_att", 32'(att4), 32'h0);
        chk("skip_tgt", 32'(tgt4), 32'h2);

        // ---------------- 4 players: lowest-alive start, win by player 2 ----------------
        clr4_n = 1'b0;
        #1;
        clr4_n = 1'b1; alive4 = 4'b1100; start4 = 1'b1;
        tick();
        start4 = 1'b0;
        chk("low_start_att", 32'(att4), 32'h2);
        chk("low_start_tgt", 32'(tgt4), 32'h3);
        fire4 = 4'b0100; ok4 = 1'b1;
        tick();
        alive4 = 4'b0100; fire4 = 4'b0000;
        tick();
        tick();
        chk("p4_over_go",   32'(go4),   32'h1);
        chk("p4_over_win",  32'(win4),  32'h2);
        chk("p4_over_disp", 32'(disp4), 32'hFBF);

`ifdef BS_TURN_TIMEOUT_EN
        // ---------------- aim timeout ----------------
        clr4_n = 1'b0;
        #1;
        clr4_n = 1'b1; alive4 = 4'b1111; start4 = 1'b1;
        tick();
        start4 = 1'b0;
        atk_seen = 4'b0000;
        for (int c = 0; c < 9; c++) begin
            tick();
            atk_seen = atk_seen | atk_ld4 | tgt_ld4;
        end
        chk("tmo_att",   32'(att4),     32'h1);
        chk("tmo_no_ld", 32'(atk_seen), 32'h0);
        for (int c = 0; c < 7; c++) tick();
        fire4 = 4'b0010;
        tick();
        chk("tmo_fire_wins", 32'(atk_ld4), 32'h2);
        fire4 = 4'b0000;
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
